perf_counter_readout_engine: RTL and testbench

// - Initiator side of the cache performance-counter comm interface: drives comm selects, reads registered return words.
// - Sweeps a masked set of 5-bit stat addresses; streams each 32-bit result over valid/ready with its address.
// - Sits between the host/debug bridge and the L1/L2 performance controllers; replaces software poke-and-read loops.

---
 rtl/perf_counter_readout_engine.sv | 185 ++++++++++++++++++
 tb/tb_perf_counter_readout_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_readout_engine.sv
// Performance-counter readout initiator: sweeps masked stat addresses over the comm interface and streams words on valid/ready.
// Define READOUT_CHECKSUM_EN to append an XOR checksum word (addr 5'h1F) to every sweep.
module perf_counter_readout_engine #(
   parameter logic [31:0] ADDR_MASK  = 32'h000F_BFFF,
   parameter int          RD_LATENCY = 2
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        count_en_i,
   input  logic        freeze_i,
   output logic [31:0] comm_o,
   input  logic [31:0] comm_i,
   output logic [31:0] word_o,
   output logic [4:0]  addr_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        last_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LATENCY - 1);

   // {found, index} of the lowest set mask bit
   function automatic logic [5:0] first_set(input logic [31:0] m);
      logic [5:0] r;
      r = '0;
      for (int i = 31; i >= 0; i--) begin
         if (m[i]) r = {1'b1, 5'(i)};
      end
      return r;
   endfunction

   localparam logic [5:0] FIRST = first_set(ADDR_MASK);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_PUSH, S_CSUM, S_DONE} state_t;

   state_t          r_state, w_next_state;
   logic [4:0]      r_addr;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_word;
   logic [4:0]      r_addr_o;
   logic            r_valid;
   logic            r_last;
   logic            w_has_next;
   logic [4:0]      w_next_addr;
   logic            w_cnt_en;
`ifdef READOUT_CHECKSUM_EN
   logic [31:0]     r_acc;
`endif

   // Lowest set mask bit strictly above the current index; no wrap past 31
   always_comb begin
      w_has_next  = 1'b0;
      w_next_addr = '0;
      for (int i = 31; i >= 0; i--) begin
         if (ADDR_MASK[i] && (i > int'(r_addr))) begin
            w_has_next  = 1'b1;
            w_next_addr = 5'(i);
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               if (FIRST[5]) w_next_state = S_SETTLE;
`ifdef READOUT_CHECKSUM_EN
               else          w_next_state = S_CSUM;
`else
               else          w_next_state = S_DONE;
`endif
            end
         end
         S_SETTLE: if (r_cnt == '0) w_next_state = S_PUSH;
         S_PUSH: begin
            if (ready_i) begin
               if (w_has_next) w_next_state = S_SETTLE;
`ifdef READOUT_CHECKSUM_EN
               else            w_next_state = S_CSUM;
`else
               else            w_next_state = S_DONE;
`endif
            end
         end
`ifdef READOUT_CHECKSUM_EN
         S_CSUM: if (r_valid && ready_i) w_next_state = S_DONE;
`endif
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o   = (r_state != S_IDLE);
      done_o   = (r_state == S_DONE);
      w_cnt_en = count_en_i & ~(freeze_i & busy_o);
      comm_o   = {7'b0, w_cnt_en, 19'b0, r_addr};
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_addr   <= '0;
         r_cnt    <= '0;
         r_word   <= '0;
         r_addr_o <= '0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
         r_acc    <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
`ifdef READOUT_CHECKSUM_EN
                  r_acc <= '0;
`endif
                  if (FIRST[5]) begin
                     r_addr <= FIRST[4:0];
                     r_cnt  <= CNT_LOAD;
                  end
               end
            end
            S_SETTLE: begin
               if (r_cnt == '0) begin
                  r_word   <= comm_i;
                  r_addr_o <= r_addr;
                  r_valid  <= 1'b1;
`ifdef READOUT_CHECKSUM_EN
                  r_last   <= 1'b0;
`else
                  r_last   <= ~w_has_next;
`endif
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_PUSH: begin
               if (ready_i) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
                  r_acc   <= r_acc ^ r_word;
`endif
                  if (w_has_next) begin
                     r_addr <= w_next_addr;
                     r_cnt  <= CNT_LOAD;
                  end
               end
            end
`ifdef READOUT_CHECKSUM_EN
            // First CSUM cycle loads the accumulator (already holding the last word)
            S_CSUM: begin
               if (!r_valid) begin
                  r_word   <= r_acc;
                  r_addr_o <= 5'h1F;
                  r_last   <= 1'b1;
                  r_valid  <= 1'b1;
               end else if (ready_i) begin
                  r_valid  <= 1'b0;
                  r_last   <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign word_o  = r_word;
   assign addr_o  = r_addr_o;
   assign valid_o = r_valid;
   assign last_o  = r_last;

endmodule

// File: tb/tb_perf_counter_readout_engine.sv
// Bench for perf_counter_readout_engine: four mask/latency variants share stimulus; a sweep-list model checks every cycle.
module tb_perf_counter_readout_engine;

   localparam int NI = 4;
   localparam logic [31:0] MASK [NI] = '{32'h0000_0003, 32'h0000_0000, 32'h8000_4811, 32'h000F_BFFF};
   localparam int          LAT  [NI] = '{2, 2, 3, 2};
`ifdef READOUT_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
   localparam int EXP_HS = 3, EXP_LAST1 = 0, EXP_BUSY1 = 3, EXP_VAL1 = 1, EXP_DONE1 = 3, EXP_C24 = 9;
`else
   localparam bit CSUM = 1'b0;
   localparam int EXP_HS = 2, EXP_LAST1 = 1, EXP_BUSY1 = 1, EXP_VAL1 = 0, EXP_DONE1 = 1, EXP_C24 = 7;
`endif

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, count_en = 1'b0, freeze = 1'b0, ready = 1'b1;
   logic [31:0] comm_o [NI];
   logic [31:0] comm_i [NI];
   logic [31:0] word_o [NI];
   logic [4:0]  addr_o [NI];
   logic        valid_o[NI], last_o[NI], busy_o[NI], done_o[NI];

   int          checks = 0, failures = 0, cyc = 0, mode = 0;
   logic [31:0] seed = 32'h0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      perf_counter_readout_engine #(.ADDR_MASK(MASK[g]), .RD_LATENCY(LAT[g])) u_dut (
         .clock_i(clk), .reset_i(rst), .start_i(start), .count_en_i(count_en), .freeze_i(freeze),
         .comm_o(comm_o[g]), .comm_i(comm_i[g]), .word_o(word_o[g]), .addr_o(addr_o[g]),
         .valid_o(valid_o[g]), .ready_i(ready), .last_o(last_o[g]), .busy_o(busy_o[g]), .done_o(done_o[g]));
   end

   function automatic logic [31:0] data_fn(input logic [4:0] a);
      case (mode)
         0:       return 32'hA0 + {27'b0, a};
         1:       return (a == 5'd0) ? 32'h1234_5678 : (a == 5'd1) ? 32'h0F0F_0F0F : (32'hDEAD_0000 | {27'b0, a});
         default: return seed ^ ({27'b0, a} * 32'h9E37_79B9);
      endcase
   endfunction

   // Controller: registered return word of the requested address
   always @(posedge clk) for (int j = 0; j < NI; j++) comm_i[j] <= data_fn(comm_o[j][4:0]);

   task automatic chk(input string nm, input int j, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", nm, j, cyc, act, exp);
      end
   endtask

   // Model: at start the whole sweep is listed; each item shows up a fixed gap after the previous acceptance
   typedef struct packed { logic [31:0] w; logic [4:0] a; logic l; } item_t;
   item_t      items [NI][33];
   int         n_items[NI], m_idx[NI], m_timer[NI];
   bit         m_active[NI], m_vis[NI], m_done[NI];
   logic [4:0] m_caddr[NI];

   function automatic int gap(input int j, input int k);
      if (CSUM && k == n_items[j] - 1) return 1;
      return LAT[j];
   endfunction

   task automatic build(input int j);
      logic [31:0] x;
      x = '0;
      n_items[j] = 0;
      for (int a = 0; a < 32; a++) begin
         if (MASK[j][a]) begin
            items[j][n_items[j]] = '{data_fn(5'(a)), 5'(a), 1'b0};
            x ^= data_fn(5'(a));
            n_items[j]++;
         end
      end
      if (CSUM) begin
         items[j][n_items[j]] = '{x, 5'h1F, 1'b1};
         n_items[j]++;
      end else if (n_items[j] > 0) begin
         items[j][n_items[j]-1].l = 1'b1;
      end
   endtask

   task automatic begin_item(input int j);
      m_timer[j] = gap(j, m_idx[j]);
      if (!(CSUM && m_idx[j] == n_items[j] - 1)) m_caddr[j] = items[j][m_idx[j]].a;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      for (int j = 0; j < NI; j++) begin
         if (rst) begin
            m_active[j] = 0; m_vis[j] = 0; m_done[j] = 0; m_caddr[j] = '0;
         end else if (m_done[j]) begin
            m_done[j] = 0; m_active[j] = 0;
         end else if (!m_active[j]) begin
            if (start) begin
               build(j);
               m_active[j] = 1;
               m_idx[j] = 0;
               if (n_items[j] == 0) m_done[j] = 1;
               else                 begin_item(j);
            end
         end else if (!m_vis[j]) begin
            m_timer[j]--;
            if (m_timer[j] == 0) m_vis[j] = 1;
         end else if (ready) begin
            m_vis[j] = 0;
            m_idx[j]++;
            if (m_idx[j] == n_items[j]) m_done[j] = 1;
            else                        begin_item(j);
         end
      end
   end

   // Per-cycle comparison plus logs used by the literal checks
   int          hs_n, hs_cyc[8], done0_cyc, done1_cyc, busy1_n, valid1_n, c24zero0, a0_valid_n;
   logic [31:0] hs_w[8];
   logic [4:0]  hs_a[8];
   logic        hs_l[8];

   task automatic clear_logs();
      hs_n = 0; done0_cyc = -1; done1_cyc = -1; busy1_n = 0; valid1_n = 0; c24zero0 = 0; a0_valid_n = 0;
      for (int k = 0; k < 8; k++) begin hs_cyc[k] = -1; hs_w[k] = '0; hs_a[k] = '0; hs_l[k] = 1'b0; end
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         for (int j = 0; j < NI; j++) begin
            chk("busy", j, 32'(busy_o[j]), 32'(m_active[j]));
            chk("done", j, 32'(done_o[j]), 32'(m_done[j]));
            chk("valid", j, 32'(valid_o[j]), 32'(m_vis[j]));
            chk("comm", j, comm_o[j], {7'b0, count_en & ~(freeze & m_active[j]), 19'b0, m_caddr[j]});
            if (m_vis[j]) begin
               chk("word", j, word_o[j], items[j][m_idx[j]].w);
               chk("addr", j, 32'(addr_o[j]), 32'(items[j][m_idx[j]].a));
               chk("last", j, 32'(last_o[j]), 32'(items[j][m_idx[j]].l));
            end
         end
         if (valid_o[0] && ready && hs_n < 8) begin
            hs_cyc[hs_n] = cyc; hs_w[hs_n] = word_o[0]; hs_a[hs_n] = addr_o[0]; hs_l[hs_n] = last_o[0];
            hs_n++;
         end
         if (done_o[0]) done0_cyc = cyc;
         if (done_o[1]) done1_cyc = cyc;
         if (busy_o[1]) busy1_n++;
         if (valid_o[1]) valid1_n++;
         if (!comm_o[0][24]) c24zero0++;
         if (valid_o[0] && addr_o[0] == 5'd0) a0_valid_n++;
      end
   end

   int start_cyc;

   task automatic do_start();
      @(posedge clk); #2 start = 1'b1; start_cyc = cyc;
      @(posedge clk); #2 start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int n = 0; n < 600 && !ok; n++) begin
         @(negedge clk); #1;
         ok = 1;
         for (int j = 0; j < NI; j++) if (busy_o[j]) ok = 0;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL wait_idle timeout cyc=%0d", cyc); end
   endtask

   task automatic wait_valid0();
      bit ok;
      ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk); #1;
         ok = valid_o[0];
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL wait_valid0 timeout cyc=%0d", cyc); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_logs();
      count_en = 1'b1;
      repeat (2) @(negedge clk);
      for (int j = 0; j < NI; j++) begin
         chk("rst_word", j, word_o[j], 32'h0);
         chk("rst_addr", j, 32'(addr_o[j]), 32'h0);
         chk("rst_flags", j, {28'b0, valid_o[j], last_o[j], busy_o[j], done_o[j]}, 32'h0);
         chk("rst_comm", j, comm_o[j], 32'h0100_0000);
      end
      @(posedge clk); #2 rst = 1'b0; count_en = 1'b0;

      // Two-word sweep at full rate, zero-mask sweep alongside
      clear_logs();
      do_start();
      wait_idle();
      chk("d1_hs_n", 0, 32'(hs_n), 32'(EXP_HS));
      chk("d1_w0", 0, hs_w[0], 32'hA0);
      chk("d1_a0", 0, 32'(hs_a[0]), 32'h0);
      chk("d1_w1", 0, hs_w[1], 32'hA1);
      chk("d1_a1", 0, 32'(hs_a[1]), 32'h1);
      chk("d1_last1", 0, 32'(hs_l[1]), 32'(EXP_LAST1));
      chk("d1_lat", 0, 32'(hs_cyc[0] - start_cyc), 32'd3);
      chk("d1_gap", 0, 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      chk("d1_done", 0, 32'(done0_cyc), 32'(hs_cyc[(hs_n > 0) ? hs_n - 1 : 0] + 1));
      chk("z_done", 1, 32'(done1_cyc - start_cyc), 32'(EXP_DONE1));
      chk("z_busy", 1, 32'(busy1_n), 32'(EXP_BUSY1));
      chk("z_valid", 1, 32'(valid1_n), 32'(EXP_VAL1));

      // Freeze snapshot
      count_en = 1'b1; freeze = 1'b1;
      clear_logs();
      do_start();
      wait_idle();
      chk("frz_c24", 0, 32'(c24zero0), 32'(EXP_C24));
      count_en = 1'b0; freeze = 1'b0;

      // Backpressure: 5 stalled cycles on the first word
      ready = 1'b0;
      clear_logs();
      do_start();
      wait_valid0();
      repeat (5) @(posedge clk);
      #2 ready = 1'b1;
      wait_idle();
      chk("stall_hold", 0, 32'(a0_valid_n), 32'd6);
      chk("stall_w0", 0, hs_w[0], 32'hA0);

      // Fixed data words and their checksum
      mode = 1;
      clear_logs();
      do_start();
      wait_idle();
      chk("fx_w0", 0, hs_w[0], 32'h1234_5678);
      chk("fx_w1", 0, hs_w[1], 32'h0F0F_0F0F);
`ifdef READOUT_CHECKSUM_EN
      chk("cs_word", 0, hs_w[2], 32'h1D3B_5977);
      chk("cs_addr", 0, 32'(hs_a[2]), 32'h1F);
      chk("cs_last", 0, 32'(hs_l[2]), 32'h1);
`endif

      // Reset pulse while a word is presented
      mode = 0; ready = 1'b0;
      do_start();
      wait_valid0();
      rst = 1'b1;
      #1;
      chk("arst_valid", 0, 32'(valid_o[0]), 32'h0);
      chk("arst_busy", 0, 32'(busy_o[0]), 32'h0);
      @(posedge clk); #2 rst = 1'b0; ready = 1'b1;
      clear_logs();
      do_start();
      wait_idle();
      chk("arst_restart_a", 0, 32'(hs_a[0]), 32'h0);
      chk("arst_restart_w", 0, hs_w[0], 32'hA0);

      // Random traffic, two data seeds
      for (int ph = 0; ph < 2; ph++) begin
         mode = 2; seed = $urandom;
         for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            start    = ($urandom_range(0, 7) == 0);
            ready    = ($urandom_range(0, 3) != 0);
            count_en = 1'($urandom);
            freeze   = 1'($urandom);
         end
         #0 start = 1'b0; ready = 1'b1;
         wait_idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
